// File: rtl/imem_loader_pkg.sv
// Shared state encoding and word/header geometry for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        LOAD,
        CHK,
        RUN,
        ERR
    } loader_state_t;

    localparam int HDR_BYTES      = 2;
    localparam int IMEM_DW        = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses with the 4th byte of each word.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               arst,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               word_valid,
    output logic [IMEM_DW-1:0] word
);

    logic [LANE_W-1:0]  lane;
    logic [IMEM_DW-9:0] partial;

    // The completing byte is spliced in combinationally so the parent can register the full word on that edge.
    assign word_valid = byte_valid && (lane == LANE_W'(BYTES_PER_WORD - 1));
    assign word       = {byte_data, partial};

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            lane    <= '0;
            partial <= '0;
        end else if (clear) begin
            lane    <= '0;
        end else if (byte_valid) begin
            lane    <= lane + LANE_W'(1);
            partial <= {byte_data, partial[IMEM_DW-9:8]};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: header + byte stream -> instruction memory writes, then releases the CPU reset.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [IMEM_DW-1:0] imem_wdata,
    output logic               cpu_rst_n,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    loader_state_t      state;
    loader_state_t      state_next;
    logic [7:0]         count_lo;
    logic [15:0]        n_words;
    logic [15:0]        hdr_count;
    logic [ADDR_W:0]    index;
    logic [16:0]        index_inc;
    logic               load_full;
    logic               xfer;
    logic               byte_to_packer;
    logic               word_valid;
    logic [IMEM_DW-1:0] word;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_LOAD = CHK;
    logic [7:0] csum;
`else
    localparam loader_state_t AFTER_LOAD = RUN;
`endif

    // load_full closes the input during the final write strobe so no byte beyond the image is taken.
    assign rx_ready       = (state == HDR0) || (state == HDR1) || (state == CHK) ||
                            ((state == LOAD) && !load_full);
    assign xfer           = rx_valid && rx_ready;
    assign byte_to_packer = xfer && (state == LOAD);
    assign hdr_count      = {rx_data, count_lo};
    assign index_inc      = 17'(index) + 17'd1;

    byte_word_packer u_packer (
        .clk        (clk),
        .arst       (arst),
        .clear      (state != LOAD),
        .byte_valid (byte_to_packer),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = HDR0;
            HDR0: if (xfer) state_next = HDR1;
            HDR1: begin
                if (xfer) begin
                    if (hdr_count == 16'd0)
                        state_next = AFTER_LOAD;
                    else if (17'(hdr_count) > DEPTH)
                        state_next = ERR;
                    else
                        state_next = LOAD;
                end
            end
            LOAD: if (load_full) state_next = AFTER_LOAD;
`ifdef LOADER_CHECKSUM_EN
            CHK:  if (xfer) state_next = (rx_data == csum) ? RUN : ERR;
`else
            CHK:  state_next = IDLE;
`endif
            RUN:  if (start) state_next = HDR0;
            ERR:  if (start) state_next = HDR0;
            default: state_next = IDLE;
        endcase
    end

    // Status flags follow the next state so they line up with it; cpu_rst_n trails RUN by one cycle.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= state_next inside {HDR0, HDR1, LOAD, CHK};
            done      <= (state_next == RUN);
            error     <= (state_next == ERR);
            cpu_rst_n <= (state == RUN);
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            count_lo   <= '0;
            n_words    <= '0;
            index      <= '0;
            load_full  <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= word_valid;
            if (start && (state inside {IDLE, RUN, ERR})) begin
                index     <= '0;
                load_full <= 1'b0;
            end
            if (xfer && (state == HDR0))
                count_lo <= rx_data;
            if (xfer && (state == HDR1))
                n_words <= hdr_count;
            if (word_valid) begin
                imem_wdata <= word;
                imem_addr  <= index[ADDR_W-1:0];
                index      <= index + (ADDR_W+1)'(1);
                load_full  <= (index_inc == 17'(n_words));
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge arst) begin
        if (!arst)
            csum <= '0;
        else if (start && (state inside {IDLE, RUN, ERR}))
            csum <= '0;
        else if (byte_to_packer)
            csum <= csum ^ rx_data;
    end
`endif

endmodule
